// File: rtl/intersection_sequencer.sv
// Timer-driven highway/country intersection phase sequencer with all-red clearance
// and capped country green. Optional emergency preemption is enabled by `define PREEMPT_EN.
module intersection_sequencer #(
    parameter int MIN_GREEN       = 8,
    parameter int Y2R_DLY         = 3,
    parameter int R2G_DLY         = 2,
    parameter int MAX_CNTRY_GREEN = 10,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       x,
`ifdef PREEMPT_EN
    input  logic       preempt,
`endif
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] phase,
    output logic       timeout
);

    localparam logic [2:0] HWY_GREEN    = 3'd0;
    localparam logic [2:0] HWY_YELLOW   = 3'd1;
    localparam logic [2:0] ALL_RED_A    = 3'd2;
    localparam logic [2:0] CNTRY_GREEN  = 3'd3;
    localparam logic [2:0] CNTRY_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_B    = 3'd5;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    localparam logic [CNT_W-1:0] TMR_ONE = CNT_W'(1);

    // Reload value (duration-1) for the state being entered.
    function automatic logic [CNT_W-1:0] dwell(input logic [2:0] s);
        case (s)
            HWY_GREEN:                dwell = CNT_W'(MIN_GREEN - 1);
            HWY_YELLOW, CNTRY_YELLOW: dwell = CNT_W'(Y2R_DLY - 1);
            CNTRY_GREEN:              dwell = CNT_W'(MAX_CNTRY_GREEN - 1);
            default:                  dwell = CNT_W'(R2G_DLY - 1);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        sat_dec = (v == '0) ? v : v - TMR_ONE;
    endfunction

    logic             r_x_p0;
    logic             r_x_p1;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_tmr;
    logic             r_timeout;
    logic             w_x_s;
    logic             w_p_s;
    logic             w_tmr_done;
    logic [2:0]       w_next;
    logic             w_force;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_x_p0 <= 1'b0;
            r_x_p1 <= 1'b0;
        end else begin
            r_x_p0 <= x;
            r_x_p1 <= r_x_p0;
        end
    end
    assign w_x_s = r_x_p1;

`ifdef PREEMPT_EN
    logic r_p_p0;
    logic r_p_p1;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_p_p0 <= 1'b0;
            r_p_p1 <= 1'b0;
        end else begin
            r_p_p0 <= preempt;
            r_p_p1 <= r_p_p0;
        end
    end
    assign w_p_s = r_p_p1;
`else
    assign w_p_s = 1'b0;
`endif

    assign w_tmr_done = (r_tmr == '0);

    // Expiry of the country-green cap takes priority over the car leaving, so timeout still pulses.
    always_comb begin
        w_next  = r_state;
        w_force = 1'b0;
        case (r_state)
            HWY_GREEN: begin
                if (w_tmr_done && w_x_s && !w_p_s) w_next = HWY_YELLOW;
            end
            HWY_YELLOW: begin
                if (w_tmr_done) w_next = w_p_s ? ALL_RED_B : ALL_RED_A;
            end
            ALL_RED_A: begin
                if (w_p_s)           w_next = ALL_RED_B;
                else if (w_tmr_done) w_next = CNTRY_GREEN;
            end
            CNTRY_GREEN: begin
                if (w_p_s) begin
                    w_next = CNTRY_YELLOW;
                end else if (w_tmr_done) begin
                    w_next  = CNTRY_YELLOW;
                    w_force = 1'b1;
                end else if (!w_x_s) begin
                    w_next = CNTRY_YELLOW;
                end
            end
            CNTRY_YELLOW: begin
                if (w_tmr_done) w_next = ALL_RED_B;
            end
            ALL_RED_B: begin
                if (w_tmr_done) w_next = HWY_GREEN;
            end
            default: w_next = ALL_RED_B;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state   <= HWY_GREEN;
            r_tmr     <= CNT_W'(MIN_GREEN - 1);
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_tmr     <= (w_next != r_state) ? dwell(w_next) : sat_dec(r_tmr);
            r_timeout <= w_force;
        end
    end

    always_comb begin
        hwy   = LAMP_RED;
        cntry = LAMP_RED;
        case (r_state)
            HWY_GREEN:    hwy   = LAMP_GREEN;
            HWY_YELLOW:   hwy   = LAMP_YELLOW;
            CNTRY_GREEN:  cntry = LAMP_GREEN;
            CNTRY_YELLOW: cntry = LAMP_YELLOW;
            default: begin
                hwy   = LAMP_RED;
                cntry = LAMP_RED;
            end
        endcase
    end

    assign phase   = r_state;
    assign timeout = r_timeout;

endmodule
